regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 16-bit, 15-entry register file. Shares the register file's single write port between several writeback sources (ALU, load unit, multi-cycle FP unit) using round-robin arbitration, and registers the winning write onto the port. Tracks a busy bit per architectural register, reserved at issue and cleared on commit, so the issue stage can stall on read-after-write hazards. Sits between the execute/memory stages and the register file write port.

## Interface
- `NREQ`, 3, number of writeback requesters; index 0 is the ALU, 1 is load, 2 is FP.
- `DW`, 16, data width.
- `AW`, 4, register address width; address 15 is the PC-mapped read-only register.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_addr`  in  NREQ x AW  destination register per requester.
- `req_data`  in  NREQ x DW  write data per requester.
- `req_ready`  out  NREQ  one-hot grant, combinational; the transfer happens when `req_valid[i] & req_ready[i]`.
- `rf_wr_en`  out  1  register file write enable, registered.
- `rf_wr_addr`  out  AW  register file write address, registered.
- `rf_wr_data`  out  DW  register file write data, registered.
- `rsv_valid`  in  1  issue stage requests a reservation of `rsv_addr`.
- `rsv_addr`  in  AW  register to reserve.
- `rsv_ok`  out  1  combinational; `rsv_addr` is in 0..14 and not busy. A reservation takes effect only when `rsv_valid & rsv_ok`.
- `chk_addr_0`, `chk_addr_1`  in  AW  source operands to hazard-check.
- `chk_busy_0`, `chk_busy_1`  out  1  combinational busy bit for each check address; always 0 for address 15.
- `busy_mask`  out  15  current busy bits, registered state.
- `drop_r15`  out  1  one-cycle registered pulse: the accepted write targeted r15 and was discarded.
- `err_unreserved`  out  1  one-cycle registered pulse: the accepted write targeted a register that was not busy.

## Operation
- **Arbitration.**
  - Round-robin pointer `last` holds the most recently granted index.
  - Priority order is `last+1`, `last+2`, …, wrapping modulo NREQ.
  - `req_ready` is one-hot for the highest-priority valid requester, and all zeros when none is valid.
  - At most one grant per cycle.
  - `last` updates only on a completed transfer.
- **Registered write port.**
  - On a transfer to address 0..14: `rf_wr_en`=1, `rf_wr_addr`=`req_addr[g]` and `rf_wr_data`=`req_data[g]` on the next cycle.
  - Otherwise `rf_wr_en`=0.
  - `rf_wr_addr` and `rf_wr_data` hold their previous values when `rf_wr_en`=0.
- **r15 writes.** A transfer to address 15 is accepted (grant issued, `last` advances) but produces no `rf_wr_en`. `drop_r15` pulses next cycle.
- **Scoreboard clear.** `busy[a]` clears on the edge where `rf_wr_en`=1 and `rf_wr_addr`=a, i.e. the same edge the register file commits. This guarantees that a reader seeing not-busy also reads committed data.
- **Scoreboard set.** `busy[a]` sets on the edge where `rsv_valid & rsv_ok`.
- **Set vs. clear on the same register in one cycle.** This cannot occur: `rsv_ok` is 0 for a busy register, including one that is being cleared in that cycle.
- **Set and clear on different registers in one cycle.** Both happen.
- **Unreserved write.** A transfer to a non-busy register in 0..14 is still written, and `err_unreserved` pulses next cycle.

## Timing
- **Reset values** (while `reset`=0, asynchronously):
  - `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0.
  - `busy_mask`=0, `drop_r15`=0, `err_unreserved`=0.
  - `last`=NREQ-1, so requester 0 has priority first.
- **Reset asserted mid-operation.** Pending `rf_wr_en` is killed, all reservations are lost, and no write reaches the register file.
- **Latencies.**
  - Grant: 0 cycles (combinational).
  - Handshake to `rf_wr_en`: 1 cycle.
  - Handshake to busy clear: 2 edges.
  - Reserve to busy visible on `chk_busy`/`busy_mask`: 1 cycle.
- **Throughput.** One write per cycle sustained; each requester is guaranteed a grant within NREQ cycles while valid.
- **Valid-hold rule.** A requester must hold `req_valid`, `req_addr` and `req_data` stable until the cycle it is granted.

## Test plan
- **Reset and single write.** Hold `reset` low, then release. Reserve r3, then send ALU write r3=0x1234. Required:
  - `rf_wr_en`=1, addr=3, data=0x1234 one cycle after the grant.
  - `busy_mask[3]` goes 1, then clears at the commit edge.
- **Round-robin fairness.** All three requesters valid continuously after reset, each with a reserved address. Required grant order: 0, 1, 2, 0, 1, 2; exactly one `req_ready` bit is high per cycle.
- **Reserve vs. clear collision.** `rsv_valid` on r5 in the same cycle r5 is committing. Required: `rsv_ok`=0 that cycle; `rsv_ok`=1 the next cycle.
- **r15 write.** Load unit writes addr 15 with data 0xBEEF. Required:
  - `req_ready[1]`=1.
  - `rf_wr_en` stays 0.
  - `drop_r15` pulses 1 cycle.
  - The next grant goes to requester 2.
- **Unreserved write and r15 reservation.**
  - FP unit writes non-busy r7: required write performed and `err_unreserved` pulses.
  - Reserve r15: required `rsv_ok`=0 and `busy_mask` unchanged.
- **Mid-operation reset.** Assert `reset` low the cycle after a handshake. Required: `rf_wr_en`=0 immediately, `busy_mask`=0, and requester 0 wins first after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port: round-robin grant among
// writeback sources, registered write port, and per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_wr_en,
    output logic [AW-1:0]        rf_wr_addr,
    output logic [DW-1:0]        rf_wr_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ok,
    input  logic [AW-1:0]        chk_addr_0,
    input  logic [AW-1:0]        chk_addr_1,
    output logic                 chk_busy_0,
    output logic                 chk_busy_1,
    output logic [(2**AW)-2:0]   busy_mask,
    output logic                 drop_r15,
    output logic                 err_unreserved
);

    localparam int             NREG     = 2**AW;
    localparam int             IW       = $clog2(NREQ);
    localparam logic [AW-1:0]  PC_ADDR  = AW'(NREG - 1);
    localparam logic [IW-1:0]  LAST_RST = IW'(NREQ - 1);
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [IW-1:0]   last_r;
    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   gidx_s;
    logic [IW-1:0]   idx_s;
    logic            hit_s;
    logic            xfer_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            wr_ok_s;

    logic [NREG-2:0] busy_r;
    logic [NREG-1:0] busy_ext_s;
    logic [NREG-1:0] clr_s;
    logic [NREG-1:0] set_s;
    logic [NREG-2:0] busy_nxt_s;
    logic            rsv_ok_s;

    logic            rf_wr_en_r;
    logic [AW-1:0]   rf_wr_addr_r;
    logic [DW-1:0]   rf_wr_data_r;
    logic            drop_r15_r;
    logic            err_unreserved_r;

    // Round-robin grant: scan from last+1 upward, first valid requester wins.
    always_comb begin
        grant_s = '0;
        gidx_s  = last_r;
        idx_s   = '0;
        hit_s   = 1'b0;
        xfer_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s          = IW'((int'(last_r) + k) % NREQ);
            hit_s          = ~xfer_s & req_valid[idx_s];
            grant_s[idx_s] = hit_s;
            gidx_s         = hit_s ? idx_s : gidx_s;
            xfer_s         = xfer_s | hit_s;
        end
        sel_addr_s = req_addr[gidx_s*AW +: AW];
        sel_data_s = req_data[gidx_s*DW +: DW];
        wr_ok_s    = xfer_s & (sel_addr_s != PC_ADDR);
    end

    // Scoreboard next state; r15 is never busy so it reads as zero here.
    always_comb begin
        busy_ext_s = {1'b0, busy_r};
        rsv_ok_s   = (rsv_addr != PC_ADDR) & ~busy_ext_s[rsv_addr];
        clr_s      = rf_wr_en_r ? (ONE_HOT0 << rf_wr_addr_r) : '0;
        set_s      = (rsv_valid & rsv_ok_s) ? (ONE_HOT0 << rsv_addr) : '0;
        busy_nxt_s = (busy_r & ~clr_s[NREG-2:0]) | set_s[NREG-2:0];
    end

    // Arbitration pointer, registered write port, scoreboard and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r           <= LAST_RST;
            rf_wr_en_r       <= 1'b0;
            rf_wr_addr_r     <= '0;
            rf_wr_data_r     <= '0;
            busy_r           <= '0;
            drop_r15_r       <= 1'b0;
            err_unreserved_r <= 1'b0;
        end else begin
            last_r           <= xfer_s ? gidx_s : last_r;
            rf_wr_en_r       <= wr_ok_s;
            if (wr_ok_s) begin
                rf_wr_addr_r <= sel_addr_s;
                rf_wr_data_r <= sel_data_s;
            end else begin
                rf_wr_addr_r <= rf_wr_addr_r;
                rf_wr_data_r <= rf_wr_data_r;
            end
            busy_r           <= busy_nxt_s;
            drop_r15_r       <= xfer_s & (sel_addr_s == PC_ADDR);
            err_unreserved_r <= wr_ok_s & ~busy_ext_s[sel_addr_s];
        end
    end

    assign req_ready      = grant_s;
    assign rsv_ok         = rsv_ok_s;
    assign chk_busy_0     = busy_ext_s[chk_addr_0];
    assign chk_busy_1     = busy_ext_s[chk_addr_1];
    assign busy_mask      = busy_r;
    assign rf_wr_en       = rf_wr_en_r;
    assign rf_wr_addr     = rf_wr_addr_r;
    assign rf_wr_data     = rf_wr_data_r;
    assign drop_r15       = drop_r15_r;
    assign err_unreserved = err_unreserved_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a set/queue model of arbitration and register reservations.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rf_wr_en;
    logic [AW-1:0]       rf_wr_addr;
    logic [DW-1:0]       rf_wr_data;
    logic                rsv_valid = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic                rsv_ok;
    logic [AW-1:0]       chk_addr_0 = '0;
    logic [AW-1:0]       chk_addr_1 = '0;
    logic                chk_busy_0;
    logic                chk_busy_1;
    logic [14:0]         busy_mask;
    logic                drop_r15;
    logic                err_unreserved;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1),
        .chk_busy_0(chk_busy_0), .chk_busy_1(chk_busy_1),
        .busy_mask(busy_mask), .drop_r15(drop_r15), .err_unreserved(err_unreserved)
    );

    typedef struct {
        logic        en;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        drop;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] m_busy = '0;
    int          m_last = NREQ - 1;
    int          m_pend = -1;
    logic [2:0]  seen_ready;
    logic        seen_rsv_ok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write-port or status pulse must match the oldest expected transfer.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1 && (rf_wr_en || drop_r15 || err_unreserved)) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected", {61'd0, rf_wr_en, drop_r15, err_unreserved}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_wr_en", rf_wr_en, e.en);
                    chk("mon_drop_r15", drop_r15, e.drop);
                    chk("mon_err_unreserved", err_unreserved, e.err);
                    if (e.en) begin
                        chk("mon_wr_addr", rf_wr_addr, e.addr);
                        chk("mon_wr_data", rf_wr_data, e.data);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic rv, input logic [3:0] ra);
        req_valid  = v;
        req_addr   = {a2, a1, a0};
        req_data   = {d2, d1, d0};
        rsv_valid  = rv;
        rsv_addr   = ra;
        chk_addr_0 = 4'($urandom_range(0, 15));
        chk_addr_1 = ra;
    endtask

    task automatic idle();
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 4'd0);
    endtask

    // One clock: check combinational outputs against the model, queue the
    // expected transfer, advance the model past the edge, check busy state.
    task automatic step(output int g);
        logic [3:0]  a;
        logic [15:0] d;
        logic        ok;
        int          setr;
        int          newp;
        exp_t        e;
        #3;
        seen_ready  = req_ready;
        seen_rsv_ok = rsv_ok;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (m_last + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
        ok = (rsv_addr != 4'd15) && !m_busy[rsv_addr];
        chk("rsv_ok", rsv_ok, ok);
        chk("chk_busy_0", chk_busy_0, (chk_addr_0 != 4'd15) && m_busy[chk_addr_0]);
        chk("chk_busy_1", chk_busy_1, (chk_addr_1 != 4'd15) && m_busy[chk_addr_1]);
        newp = -1;
        setr = -1;
        if (g >= 0) begin
            a      = req_addr[g*AW +: AW];
            d      = req_data[g*DW +: DW];
            e.en   = (a != 4'd15);
            e.addr = a;
            e.data = d;
            e.drop = (a == 4'd15);
            e.err  = (a != 4'd15) && !m_busy[a];
            exp_q.push_back(e);
            m_last = g;
            if (a != 4'd15) newp = int'(a);
        end
        if (rsv_valid && ok) setr = int'(rsv_addr);
        @(posedge clk);
        #1;
        if (m_pend >= 0) m_busy[m_pend] = 1'b0;
        if (setr >= 0) m_busy[setr] = 1'b1;
        m_pend = newp;
        chk("busy_mask", busy_mask, m_busy[14:0]);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        rsv_valid = 1'b0;
        #1;
        chk("rst_wr_en", rf_wr_en, 1'b0);
        chk("rst_wr_addr", rf_wr_addr, 4'd0);
        chk("rst_wr_data", rf_wr_data, 16'd0);
        chk("rst_busy_mask", busy_mask, 15'd0);
        chk("rst_drop_r15", drop_r15, 1'b0);
        chk("rst_err_unreserved", err_unreserved, 1'b0);
        chk("rst_queue_empty", exp_q.size(), 64'd0);
        exp_q.delete();
        m_busy = '0;
        m_last = NREQ - 1;
        m_pend = -1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          g;
        logic        pv[3];
        logic [3:0]  pa[3];
        logic [15:0] pd[3];

        // Reset and single reserved write
        do_reset();
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd3);
        step(g);
        chk("t1_busy3_set", busy_mask[3], 1'b1);
        drive(3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'd0, 16'd0, 1'b0, 4'd0);
        step(g);
        chk("t1_wr_en", rf_wr_en, 1'b1);
        chk("t1_wr_addr", rf_wr_addr, 4'd3);
        chk("t1_wr_data", rf_wr_data, 16'h1234);
        chk("t1_busy3_still", busy_mask[3], 1'b1);
        idle();
        step(g);
        chk("t1_busy3_clear", busy_mask[3], 1'b0);

        // Round-robin fairness
        do_reset();
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd1); step(g);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd2); step(g);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd4); step(g);
        for (int r = 0; r < 6; r++) begin
            drive(3'b111, 4'd1, 4'd2, 4'd4, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 4'd0);
            step(g);
            chk("rr_order", seen_ready, 3'b001 << (r % 3));
            chk("rr_onehot", $countones(seen_ready), 64'd1);
        end
        idle(); step(g);

        // Reserve vs. commit collision on r5
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd5); step(g);
        drive(3'b001, 4'd5, 4'd0, 4'd0, 16'h5555, 16'd0, 16'd0, 1'b0, 4'd0); step(g);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd5); step(g);
        chk("col_rsv_ok_blocked", seen_rsv_ok, 1'b0);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd5); step(g);
        chk("col_rsv_ok_next", seen_rsv_ok, 1'b1);

        // r15 write from the load unit
        drive(3'b010, 4'd0, 4'd15, 4'd0, 16'd0, 16'hBEEF, 16'd0, 1'b0, 4'd0); step(g);
        chk("r15_ready", seen_ready, 3'b010);
        chk("r15_no_wr_en", rf_wr_en, 1'b0);
        chk("r15_drop", drop_r15, 1'b1);
        drive(3'b101, 4'd6, 4'd0, 4'd8, 16'h0606, 16'd0, 16'h0808, 1'b0, 4'd0); step(g);
        chk("r15_next_grant", seen_ready, 3'b100);
        chk("r15_drop_pulse_end", drop_r15, 1'b0);
        drive(3'b001, 4'd6, 4'd0, 4'd0, 16'h0606, 16'd0, 16'd0, 1'b0, 4'd0); step(g);
        idle(); step(g);

        // Unreserved FP write to r7, then reserving r15
        drive(3'b100, 4'd0, 4'd0, 4'd7, 16'd0, 16'd0, 16'h7777, 1'b0, 4'd0); step(g);
        chk("unrsv_wr_en", rf_wr_en, 1'b1);
        chk("unrsv_err", err_unreserved, 1'b1);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd15); step(g);
        chk("r15_rsv_ok", seen_rsv_ok, 1'b0);

        // Mid-operation reset
        idle(); step(g);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1, 4'd9); step(g);
        drive(3'b001, 4'd9, 4'd0, 4'd0, 16'h9999, 16'd0, 16'd0, 1'b0, 4'd0); step(g);
        #2;
        do_reset();
        drive(3'b111, 4'd1, 4'd2, 4'd3, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4'd0); step(g);
        chk("rst_first_grant", seen_ready, 3'b001);
        drive(3'b110, 4'd1, 4'd2, 4'd3, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4'd0); step(g);
        drive(3'b100, 4'd1, 4'd2, 4'd3, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4'd0); step(g);
        idle(); step(g);

        // Random traffic honouring the valid-hold rule
        do_reset();
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pd[i] = 16'($urandom);
                end
            end
            req_valid  = {pv[2], pv[1], pv[0]};
            req_addr   = {pa[2], pa[1], pa[0]};
            req_data   = {pd[2], pd[1], pd[0]};
            rsv_valid  = 1'($urandom_range(0, 1));
            rsv_addr   = 4'($urandom_range(0, 15));
            chk_addr_0 = 4'($urandom_range(0, 15));
            chk_addr_1 = 4'($urandom_range(0, 15));
            step(g);
            if (g >= 0) pv[g] = 1'b0;
        end
        idle(); step(g);
        idle(); step(g);
        idle(); step(g);
        chk("final_queue_empty", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
